aes_sca_sequencer: RTL and testbench

//  Sits directly downstream of comm: consumes aes_start/pt_to_aes, returns aes_ready/ct_from_aes.

---
 rtl/aes_sca_sequencer.sv | 157 +++++++++++++++
 tb/tb_aes_sca_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sca_sequencer.sv
// Side-channel capture sequencer: latches a plaintext from comm, drives a fixed-key iterative AES core,
// and frames each encryption with a scope trigger plus a post-completion quiet period.
module aes_sca_sequencer #(
    parameter logic [127:0] KEY      = 128'h000102030405060708090a0b0c0d0e0f,
    parameter int           TRIG_PRE = 4,
    parameter int           POST_LEN = 2,
    parameter int           TIMEOUT  = 1024,
    parameter int           CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             aes_start,
    input  logic [127:0]     pt_in,
    output logic             aes_ready,
    output logic [127:0]     ct_out,
    output logic             core_load,
    output logic [127:0]     core_pt,
    output logic [127:0]     core_key,
    input  logic             core_done,
    input  logic [127:0]     core_ct,
    output logic             trigger,
    output logic [CNT_W-1:0] enc_count,
    output logic             timeout_err
);

    localparam int MAX_AP = (TRIG_PRE > POST_LEN) ? TRIG_PRE : POST_LEN;
    localparam int MAX_V  = (MAX_AP > TIMEOUT) ? MAX_AP : TIMEOUT;
    localparam int CW     = $clog2(MAX_V + 1);

    localparam logic [CW-1:0] ARM_LAST  = CW'(TRIG_PRE - 1);
    localparam logic [CW-1:0] RUN_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(POST_LEN - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_POST = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic              r_ready, w_ready_nxt;
    logic              r_trigger, w_trigger_nxt;
    logic              r_load, w_load_nxt;
    logic [127:0]      r_core_pt, w_core_pt_nxt;
    logic [127:0]      r_ct, w_ct_nxt;
    logic [CNT_W-1:0]  r_enc, w_enc_nxt;
    logic              r_to_err, w_to_err_nxt;

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= CNT_ZERO;
            r_ready   <= 1'b1;
            r_trigger <= 1'b0;
            r_load    <= 1'b0;
            r_core_pt <= 128'd0;
            r_ct      <= 128'd0;
            r_enc     <= {CNT_W{1'b0}};
            r_to_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ready   <= w_ready_nxt;
            r_trigger <= w_trigger_nxt;
            r_load    <= w_load_nxt;
            r_core_pt <= w_core_pt_nxt;
            r_ct      <= w_ct_nxt;
            r_enc     <= w_enc_nxt;
            r_to_err  <= w_to_err_nxt;
        end
    end

    // Next-state and next-output logic; core_done is not accepted in the load cycle (cnt == 0).
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ready_nxt   = r_ready;
        w_trigger_nxt = r_trigger;
        w_load_nxt    = 1'b0;
        w_core_pt_nxt = r_core_pt;
        w_ct_nxt      = r_ct;
        w_enc_nxt     = r_enc;
        w_to_err_nxt  = r_to_err;
        case (r_state)
            S_IDLE: begin
                w_ready_nxt   = 1'b1;
                w_trigger_nxt = 1'b0;
                if (aes_start) begin
                    w_core_pt_nxt = pt_in;
                    w_trigger_nxt = 1'b1;
                    w_ready_nxt   = 1'b0;
                    w_cnt_nxt     = CNT_ZERO;
                    w_state_nxt   = S_ARM;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ARM: begin
                if (r_cnt == ARM_LAST) begin
                    w_load_nxt  = 1'b1;
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_RUN: begin
                if (core_done && (r_cnt != CNT_ZERO)) begin
                    w_ct_nxt      = core_ct;
                    w_enc_nxt     = r_enc + {{(CNT_W-1){1'b0}}, 1'b1};
                    w_trigger_nxt = 1'b0;
                    w_cnt_nxt     = CNT_ZERO;
                    w_state_nxt   = S_POST;
                end else if (r_cnt == RUN_LAST) begin
                    w_ct_nxt      = 128'd0;
                    w_to_err_nxt  = 1'b1;
                    w_trigger_nxt = 1'b0;
                    w_cnt_nxt     = CNT_ZERO;
                    w_state_nxt   = S_POST;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_POST: begin
                w_trigger_nxt = 1'b0;
                if (r_cnt == POST_LAST) begin
                    w_ready_nxt = 1'b1;
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_ready_nxt   = 1'b1;
                w_trigger_nxt = 1'b0;
                w_cnt_nxt     = CNT_ZERO;
            end
        endcase
    end

    assign aes_ready   = r_ready;
    assign ct_out      = r_ct;
    assign core_load   = r_load;
    assign core_pt     = r_core_pt;
    assign core_key    = KEY;
    assign trigger     = r_trigger;
    assign enc_count   = r_enc;
    assign timeout_err = r_to_err;

endmodule

// File: tb/tb_aes_sca_sequencer.sv
// Directed bench for aes_sca_sequencer: FIPS-197 vector, trigger timing, busy requests,
// core timeout, reset abort and enc_count wrap with a behavioural AES core driven from tasks.
module tb_aes_sca_sequencer;

    localparam logic [127:0] KEY     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         aes_start = 1'b0;
    logic [127:0] pt_in = 128'd0;
    logic         aes_ready;
    logic [127:0] ct_out;
    logic         core_load;
    logic [127:0] core_pt;
    logic [127:0] core_key;
    logic         core_done = 1'b0;
    logic [127:0] core_ct = 128'd0;
    logic         trigger;
    logic [3:0]   enc_count;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;
    logic [3:0]   exp_cnt = 4'd0;
    logic [127:0] last_ct = 128'd0;

    aes_sca_sequencer #(
        .KEY(KEY), .TRIG_PRE(4), .POST_LEN(2), .TIMEOUT(16), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .aes_start(aes_start), .pt_in(pt_in),
        .aes_ready(aes_ready), .ct_out(ct_out), .core_load(core_load),
        .core_pt(core_pt), .core_key(core_key), .core_done(core_done),
        .core_ct(core_ct), .trigger(trigger), .enc_count(enc_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one request; lat = cycles after load when the core answers (0 = never).
    task automatic do_enc(input logic [127:0] pt, input logic [127:0] ct, input int lat,
                          input bit decoy, input bit busy, output int loads, output bit done_ok);
        int k;
        loads = 0;
        k = -1;
        pt_in = pt;
        aes_start = 1'b1;
        tick();
        aes_start = 1'b0;
        for (int n = 0; n < 100 && !aes_ready; n++) begin
            core_done = 1'b0;
            aes_start = 1'b0;
            if (core_load) begin
                loads++;
                k = 0;
            end else if (k >= 0) begin
                k++;
            end
            if (busy && (n == 1 || k == 3 || (k > 0 && !trigger))) aes_start = 1'b1;
            if (k == 0 && decoy) begin
                core_done = 1'b1;
                core_ct = ~ct;
            end
            if (lat > 0 && k == lat) begin
                core_done = 1'b1;
                core_ct = ct;
            end
            pt_in = ~pt;
            tick();
        end
        core_done = 1'b0;
        aes_start = 1'b0;
        done_ok = aes_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (aes_ready !== 1'b1 || trigger !== 1'b0 || core_load !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl ready=%b trig=%b load=%b required 1 0 0", aes_ready, trigger, core_load);
        end
        checks++;
        if (ct_out !== 128'd0 || core_pt !== 128'd0 || enc_count !== 4'd0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_data ct=%h pt=%h cnt=%0d to=%b required zeros", ct_out, core_pt, enc_count, timeout_err);
        end
        checks++;
        if (core_key !== KEY) begin
            errors++;
            $display("FAIL core_key got %h required %h", core_key, KEY);
        end
    endtask

    task automatic test_fips_timing();
        bit bad;
        pt_in = FIPS_PT;
        aes_start = 1'b1;
        tick();
        aes_start = 1'b0;
        pt_in = 128'd0;
        checks++;
        if (trigger !== 1'b1 || aes_ready !== 1'b0 || core_load !== 1'b0 || core_pt !== FIPS_PT) begin
            errors++;
            $display("FAIL start_edge trig=%b ready=%b load=%b pt=%h required 1 0 0 %h", trigger, aes_ready, core_load, core_pt, FIPS_PT);
        end
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (core_load !== 1'b0 || trigger !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL arm_phase load/trigger wrong during pre-roll, required load 0 trig 1");
        end
        tick();
        checks++;
        if (core_load !== 1'b1 || trigger !== 1'b1) begin
            errors++;
            $display("FAIL load_pulse load=%b trig=%b required 1 1", core_load, trigger);
        end
        tick();
        checks++;
        if (core_load !== 1'b0) begin
            errors++;
            $display("FAIL load_width load=%b required 0", core_load);
        end
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (trigger !== 1'b1 || ct_out !== 128'd0) begin
            errors++;
            $display("FAIL run_hold trig=%b ct=%h required 1 0", trigger, ct_out);
        end
        core_done = 1'b1;
        core_ct = FIPS_CT;
        tick();
        core_done = 1'b0;
        core_ct = 128'd0;
        exp_cnt = exp_cnt + 4'd1;
        last_ct = FIPS_CT;
        checks++;
        if (ct_out !== FIPS_CT || enc_count !== exp_cnt || trigger !== 1'b0 || aes_ready !== 1'b0) begin
            errors++;
            $display("FAIL fips_result ct=%h cnt=%0d trig=%b ready=%b required %h %0d 0 0", ct_out, enc_count, trigger, aes_ready, FIPS_CT, exp_cnt);
        end
        tick();
        checks++;
        if (aes_ready !== 1'b0) begin
            errors++;
            $display("FAIL post_quiet ready=%b required 0", aes_ready);
        end
        tick();
        checks++;
        if (aes_ready !== 1'b1 || ct_out !== FIPS_CT) begin
            errors++;
            $display("FAIL ready_return ready=%b ct=%h required 1 %h", aes_ready, ct_out, FIPS_CT);
        end
    endtask

    task automatic test_busy();
        int loads;
        bit ok;
        logic [127:0] ct;
        ct = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        do_enc(128'h1, ct, 10, 1'b0, 1'b1, loads, ok);
        exp_cnt = exp_cnt + 4'd1;
        last_ct = ct;
        checks++;
        if (!ok || loads != 1 || enc_count !== exp_cnt || ct_out !== ct) begin
            errors++;
            $display("FAIL busy_ignored ok=%b loads=%0d cnt=%0d ct=%h required 1 1 %0d %h", ok, loads, enc_count, ct_out, exp_cnt, ct);
        end
        tick();
        checks++;
        if (aes_ready !== 1'b1 || trigger !== 1'b0) begin
            errors++;
            $display("FAIL busy_not_queued ready=%b trig=%b required 1 0", aes_ready, trigger);
        end
    endtask

    task automatic test_timeout();
        int loads;
        bit ok;
        aes_start = 1'b1;
        pt_in = 128'h55;
        tick();
        aes_start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (timeout_err !== 1'b0 || trigger !== 1'b1 || ct_out !== last_ct) begin
            errors++;
            $display("FAIL timeout_early to=%b trig=%b ct=%h required 0 1 %h", timeout_err, trigger, ct_out, last_ct);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1 || ct_out !== 128'd0 || trigger !== 1'b0 || enc_count !== exp_cnt) begin
            errors++;
            $display("FAIL timeout_fire to=%b ct=%h trig=%b cnt=%0d required 1 0 0 %0d", timeout_err, ct_out, trigger, enc_count, exp_cnt);
        end
        tick();
        tick();
        checks++;
        if (aes_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ready ready=%b required 1", aes_ready);
        end
        do_enc(FIPS_PT, FIPS_CT, 5, 1'b0, 1'b0, loads, ok);
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (!ok || ct_out !== FIPS_CT || enc_count !== exp_cnt || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky ok=%b ct=%h cnt=%0d to=%b required 1 %h %0d 1", ok, ct_out, enc_count, timeout_err, FIPS_CT, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        int loads;
        bit ok;
        aes_start = 1'b1;
        pt_in = 128'h77;
        tick();
        aes_start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (aes_ready !== 1'b1 || trigger !== 1'b0 || core_load !== 1'b0 || ct_out !== 128'd0 ||
            core_pt !== 128'd0 || enc_count !== 4'd0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort ready=%b trig=%b load=%b ct=%h pt=%h cnt=%0d to=%b required reset values",
                     aes_ready, trigger, core_load, ct_out, core_pt, enc_count, timeout_err);
        end
        core_done = 1'b1;
        core_ct = 128'h1234;
        tick();
        core_done = 1'b0;
        checks++;
        if (ct_out !== 128'd0 || enc_count !== 4'd0 || aes_ready !== 1'b1) begin
            errors++;
            $display("FAIL late_done ct=%h cnt=%0d ready=%b required 0 0 1", ct_out, enc_count, aes_ready);
        end
        exp_cnt = 4'd0;
        do_enc(128'h99, 128'habcd, 3, 1'b0, 1'b0, loads, ok);
        exp_cnt = exp_cnt + 4'd1;
        checks++;
        if (!ok || ct_out !== 128'habcd || enc_count !== exp_cnt) begin
            errors++;
            $display("FAIL after_reset ok=%b ct=%h cnt=%0d required 1 abcd %0d", ok, ct_out, enc_count, exp_cnt);
        end
    endtask

    task automatic test_back_to_back_wrap();
        int loads;
        bit ok;
        bit bad;
        bit wrapped;
        logic [127:0] ct;
        bad = 1'b0;
        wrapped = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ct = {96'd0, 32'(i * 32'h01010101 + 32'h11)};
            do_enc(128'(i), ct, 2, 1'b1, 1'b0, loads, ok);
            exp_cnt = exp_cnt + 4'd1;
            if (!ok || loads != 1 || ct_out !== ct || enc_count !== exp_cnt) bad = 1'b1;
            if (exp_cnt == 4'd0 && enc_count === 4'd0) wrapped = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL b2b_decoy cnt=%0d ct=%h required cnt %0d, decoy done in load cycle ignored", enc_count, ct_out, exp_cnt);
        end
        checks++;
        if (!wrapped) begin
            errors++;
            $display("FAIL cnt_wrap wrapped=%b required 1 (15 -> 0)", wrapped);
        end
    endtask

    initial begin
        test_reset();
        test_fips_timing();
        test_busy();
        test_timeout();
        test_reset_mid_run();
        test_back_to_back_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
